// File: rtl/pwm_ramp_ctrl.sv
// Period/compare sequencer for one pwm: accepts a target over valid/ready and
// ramps compare toward it in steps applied only at pwm period boundaries.
module pwm_ramp_ctrl #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned RAMP_DIV = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_peirod,
  input  logic [WIDTH-1:0] cfg_compare,
  input  logic [WIDTH-1:0] cfg_step,
  input  logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] peirod,
  output logic [WIDTH-1:0] compare,
  output logic             busy,
  output logic             done
);

  localparam int unsigned EW    = WIDTH + 1;
  localparam int unsigned DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RAMP_DIV - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RAMP = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] peirod_q, peirod_d;
  logic [WIDTH-1:0] compare_q, compare_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] tgt_peirod_q, tgt_peirod_d;
  logic [WIDTH-1:0] tgt_cmp_q, tgt_cmp_d;
  logic [WIDTH-1:0] step_q, step_d;
  logic [DIV_W-1:0] div_q, div_d;

  logic             accept;
  logic             bnd;
  logic [EW-1:0]    cur_e, tgt_e, step_e, lim_e, sum_e, dif_e, next_e;
  logic [WIDTH-1:0] cmp_step;

  assign cfg_ready = enable & (state_q != ST_RAMP);
  assign accept    = cfg_valid & cfg_ready;

  // Period boundary; a zero period counts as a boundary every cycle.
  assign bnd = (peirod_q == '0) ? 1'b1 : (count == (peirod_q - WIDTH'(1)));

  // One saturating step toward the target, computed without wrap-around.
  always_comb begin
    cur_e  = {1'b0, compare_q};
    tgt_e  = {1'b0, tgt_cmp_q};
    step_e = {1'b0, step_q};
    lim_e  = {1'b0, tgt_peirod_q};
    sum_e  = cur_e + step_e;
    dif_e  = (cur_e > step_e) ? (cur_e - step_e) : '0;
    if (cur_e < tgt_e) begin
      next_e = (sum_e > tgt_e) ? tgt_e : sum_e;
    end else begin
      next_e = (dif_e < tgt_e) ? tgt_e : dif_e;
    end
    cmp_step = (next_e > lim_e) ? tgt_peirod_q : next_e[WIDTH-1:0];
  end

  always_comb begin
    state_d      = state_q;
    peirod_d     = peirod_q;
    compare_d    = compare_q;
    done_d       = 1'b0;
    tgt_peirod_d = tgt_peirod_q;
    tgt_cmp_d    = tgt_cmp_q;
    step_d       = step_q;
    div_d        = div_q;

    if (!enable) begin
      if (bnd) begin
        compare_d = '0;
        state_d   = ST_IDLE;
      end
    end else if (accept) begin
      tgt_peirod_d = cfg_peirod;
      tgt_cmp_d    = (cfg_compare > cfg_peirod) ? cfg_peirod : cfg_compare;
      step_d       = (cfg_step == '0) ? '1 : cfg_step;
      div_d        = '0;
      state_d      = ST_RAMP;
    end else if ((state_q == ST_RAMP) && bnd) begin
      peirod_d = tgt_peirod_q;
      if (div_q == DIV_LAST) begin
        div_d     = '0;
        compare_d = cmp_step;
        if (cmp_step == tgt_cmp_q) begin
          done_d  = 1'b1;
          state_d = ST_HOLD;
        end
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end

    busy_d = (state_d == ST_RAMP);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      peirod_q     <= '0;
      compare_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      tgt_peirod_q <= '0;
      tgt_cmp_q    <= '0;
      step_q       <= '0;
      div_q        <= '0;
    end else begin
      state_q      <= state_d;
      peirod_q     <= peirod_d;
      compare_q    <= compare_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      tgt_peirod_q <= tgt_peirod_d;
      tgt_cmp_q    <= tgt_cmp_d;
      step_q       <= step_d;
      div_q        <= div_d;
    end
  end

  assign peirod  = peirod_q;
  assign compare = compare_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl: one instance per ramp divider setting,
// both driven from the same stimulus with hand-derived expectations.
module tb_pwm_ramp_ctrl;

  logic        clock;
  logic        reset;
  logic        enable;
  logic        cfg_valid;
  logic [31:0] cfg_peirod;
  logic [31:0] cfg_compare;
  logic [31:0] cfg_step;
  logic [31:0] count;

  logic        cfg_ready;
  logic [31:0] peirod;
  logic [31:0] compare;
  logic        busy;
  logic        done;

  logic        cfg_ready3;
  logic [31:0] peirod3;
  logic [31:0] compare3;
  logic        busy3;
  logic        done3;

  int vectors     = 0;
  int miscompares = 0;

  pwm_ramp_ctrl #(.WIDTH(32), .RAMP_DIV(1)) u_dut (
    .clock(clock), .reset(reset), .enable(enable),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_peirod(cfg_peirod), .cfg_compare(cfg_compare), .cfg_step(cfg_step),
    .count(count), .peirod(peirod), .compare(compare), .busy(busy), .done(done)
  );

  pwm_ramp_ctrl #(.WIDTH(32), .RAMP_DIV(3)) u_dut3 (
    .clock(clock), .reset(reset), .enable(enable),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready3),
    .cfg_peirod(cfg_peirod), .cfg_compare(cfg_compare), .cfg_step(cfg_step),
    .count(count), .peirod(peirod3), .compare(compare3), .busy(busy3), .done(done3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drive the pwm counter through lo..hi, one value per clock edge.
  task automatic run_counts(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      count = 32'(i);
      tick();
    end
  endtask

  task automatic offer(input logic [31:0] p, input logic [31:0] c, input logic [31:0] s);
    cfg_peirod  = p;
    cfg_compare = c;
    cfg_step    = s;
    cfg_valid   = 1'b1;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; cfg_valid = 1'b0;
    cfg_peirod = '0; cfg_compare = '0; cfg_step = '0; count = '0;

    // Reset state
    #1;
    chk("rst_peirod", peirod, 32'd0);
    chk("rst_compare", compare, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    tick(); tick();
    chk("rst_ready_dis", 32'(cfg_ready), 32'd0);
    enable = 1'b1;
    #1;
    chk("rst_ready_en", 32'(cfg_ready), 32'd1);
    reset = 1'b0;

    // Ramp 0 -> 3 by 1 into a period of 4
    offer(32'd4, 32'd3, 32'd1);
    count = 32'd0;
    tick();
    cfg_valid = 1'b0;
    chk("t2_acc_busy", 32'(busy), 32'd1);
    chk("t2_acc_cmp", compare, 32'd0);
    chk("t2_acc_per", peirod, 32'd0);
    chk("t2_acc_ready", 32'(cfg_ready), 32'd0);
    tick();
    chk("t2_b1_per", peirod, 32'd4);
    chk("t2_b1_cmp", compare, 32'd1);
    chk("t2_b1_done", 32'(done), 32'd0);
    run_counts(0, 2);
    chk("t2_hold_cmp", compare, 32'd1);
    run_counts(3, 3);
    chk("t2_b2_cmp", compare, 32'd2);
    chk("t2_b2_done", 32'(done), 32'd0);
    run_counts(0, 3);
    chk("t2_b3_cmp", compare, 32'd3);
    chk("t2_b3_done", 32'(done), 32'd1);
    chk("t2_b3_busy", 32'(busy), 32'd0);
    count = 32'd0;
    tick();
    chk("t2_done_off", 32'(done), 32'd0);
    chk("t2_hold_ready", 32'(cfg_ready), 32'd1);

    // From HOLD: accept coincides with a boundary, compare clipped to period
    offer(32'd2, 32'd5, 32'd2);
    count = 32'd3;
    tick();
    cfg_valid = 1'b0;
    chk("t3_acc_cmp", compare, 32'd3);
    chk("t3_acc_per", peirod, 32'd4);
    chk("t3_acc_busy", 32'(busy), 32'd1);
    chk("t3_acc_done", 32'(done), 32'd0);
    run_counts(0, 2);
    chk("t3_wait_cmp", compare, 32'd3);
    run_counts(3, 3);
    chk("t3_per", peirod, 32'd2);
    chk("t3_cmp", compare, 32'd2);
    chk("t3_done", 32'(done), 32'd1);
    chk("t3_busy", 32'(busy), 32'd0);
    count = 32'd0;
    tick();
    chk("t3_done_off", 32'(done), 32'd0);

    // Step 0 jumps in one step; divider 3 waits for the third boundary
    reset = 1'b1;
    tick();
    reset = 1'b0;
    offer(32'd8, 32'd4, 32'd0);
    count = 32'd0;
    tick();
    cfg_valid = 1'b0;
    chk("t4_busy1", 32'(busy), 32'd1);
    chk("t4_busy3", 32'(busy3), 32'd1);
    tick();
    chk("t4_d1_per", peirod, 32'd8);
    chk("t4_d1_cmp", compare, 32'd4);
    chk("t4_d1_done", 32'(done), 32'd1);
    chk("t4_d3_per", peirod3, 32'd8);
    chk("t4_d3_cmp_b1", compare3, 32'd0);
    chk("t4_d3_done_b1", 32'(done3), 32'd0);
    run_counts(0, 7);
    chk("t4_d3_cmp_b2", compare3, 32'd0);
    chk("t4_d3_done_b2", 32'(done3), 32'd0);
    chk("t4_d3_busy_b2", 32'(busy3), 32'd1);
    run_counts(0, 7);
    chk("t4_d3_cmp_b3", compare3, 32'd4);
    chk("t4_d3_done_b3", 32'(done3), 32'd1);
    chk("t4_d3_busy_b3", 32'(busy3), 32'd0);
    count = 32'd0;
    tick();
    chk("t4_d3_done_off", 32'(done3), 32'd0);

    // Disable mid-ramp at compare=2
    reset = 1'b1;
    tick();
    reset = 1'b0;
    offer(32'd4, 32'd3, 32'd1);
    count = 32'd0;
    tick();
    cfg_valid = 1'b0;
    tick();
    run_counts(0, 3);
    chk("t5_pre_cmp", compare, 32'd2);
    enable = 1'b0;
    #1;
    chk("t5_ready", 32'(cfg_ready), 32'd0);
    offer(32'd2, 32'd0, 32'd0);
    run_counts(0, 2);
    chk("t5_wait_cmp", compare, 32'd2);
    chk("t5_wait_busy", 32'(busy), 32'd1);
    run_counts(3, 3);
    chk("t5_cmp", compare, 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_done", 32'(done), 32'd0);
    chk("t5_per", peirod, 32'd4);
    cfg_valid = 1'b0;
    enable = 1'b1;
    #1;
    chk("t5_ready_idle", 32'(cfg_ready), 32'd1);
    run_counts(0, 3);
    chk("t5_idle_cmp", compare, 32'd0);
    chk("t5_idle_busy", 32'(busy), 32'd0);

    // Config offered during RAMP is refused; async reset between edges
    offer(32'd4, 32'd3, 32'd1);
    count = 32'd0;
    tick();
    cfg_valid = 1'b0;
    chk("t6_busy", 32'(busy), 32'd1);
    run_counts(1, 3);
    chk("t6_b1_cmp", compare, 32'd1);
    offer(32'd2, 32'd0, 32'd0);
    #1;
    chk("t6_ready", 32'(cfg_ready), 32'd0);
    run_counts(0, 3);
    chk("t6_b2_cmp", compare, 32'd2);
    chk("t6_b2_per", peirod, 32'd4);
    chk("t6_b2_busy", 32'(busy), 32'd1);
    cfg_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("t6_rst_per", peirod, 32'd0);
    chk("t6_rst_cmp", compare, 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_done", 32'(done), 32'd0);
    chk("t6_rst_ready", 32'(cfg_ready), 32'd1);
    tick();
    reset = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
